// File: rtl/coef_table_loader_if.sv
// Bundle of the load-stream handshake, status flags and random-read port for coef_table_loader.
// The CSUM signal exists only when COEF_TABLE_LOADER_CSUM_EN is defined.
interface coef_table_loader_if #(
  parameter int NX   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          START;
  logic [NX-1:0] IN_DATA;
  logic          IN_VALID;
  logic          IN_LAST;
  logic          IN_READY;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [RW-1:0] RD_ROW;
  logic [CLW-1:0] RD_COL;
  logic [NX-1:0] RD_DATA;
`ifdef COEF_TABLE_LOADER_CSUM_EN
  logic [NX-1:0] CSUM;

  modport master (
    output START, IN_DATA, IN_VALID, IN_LAST, RD_ROW, RD_COL,
    input  IN_READY, BUSY, DONE, ERR, RD_DATA, CSUM
  );
  modport slave (
    input  START, IN_DATA, IN_VALID, IN_LAST, RD_ROW, RD_COL,
    output IN_READY, BUSY, DONE, ERR, RD_DATA, CSUM
  );
`else
  modport master (
    output START, IN_DATA, IN_VALID, IN_LAST, RD_ROW, RD_COL,
    input  IN_READY, BUSY, DONE, ERR, RD_DATA
  );
  modport slave (
    input  START, IN_DATA, IN_VALID, IN_LAST, RD_ROW, RD_COL,
    output IN_READY, BUSY, DONE, ERR, RD_DATA
  );
`endif
endinterface

// File: rtl/coef_table_loader.sv
// Runtime loader for a ROWS x COLS coefficient table fed by a framed valid/ready stream, with a
// registered random-read port. Define COEF_TABLE_LOADER_CSUM_EN to add the CSUM frame checksum output.
module coef_table_loader #(
  parameter int NX   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input logic               CLK,
  input logic               RESET,
  coef_table_loader_if.slave bus
);
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW       = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int LAST_IDX = ROWS * COLS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [NX-1:0]   tbl_q [ROWS][COLS];
  logic [NX-1:0]   rd_data_q;
  logic [NX-1:0]   rd_data_d;
  logic            xfer;
  logic            wr_en;
  logic            cnt_at_last;
  logic [RW-1:0]   wr_row;
  logic [CLW-1:0]  wr_col;

  always_comb begin
    // IN_READY is busy_q, so a transfer is simply a valid word while a frame is open
    xfer        = bus.IN_VALID && busy_q;
    wr_en       = xfer && (state_q == LOAD);
    cnt_at_last = (cnt_q == CW'(LAST_IDX));
    wr_row      = RW'(int'(cnt_q) / COLS);
    wr_col      = CLW'(int'(cnt_q) % COLS);
    rd_data_d   = tbl_q[bus.RD_ROW][bus.RD_COL];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (bus.IN_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= cnt_at_last;
              err_q   <= !cnt_at_last;
            end else if (cnt_at_last) begin
              state_q <= FLUSH;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (xfer && bus.IN_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The read register samples the table before this edge's write lands, giving old-data on collision
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tbl_q[r][c] <= NX'(r * COLS + c);
        end
      end
    end else begin
      rd_data_q <= rd_data_d;
      if (wr_en) begin
        tbl_q[wr_row][wr_col] <= bus.IN_DATA;
      end
    end
  end

  assign bus.IN_READY = busy_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.RD_DATA  = rd_data_q;

`ifdef COEF_TABLE_LOADER_CSUM_EN
  logic [NX-1:0] csum_q;
  logic [NX-1:0] csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && bus.START) begin
      csum_d = '0;
    end else if (wr_en) begin
      csum_d = csum_q + bus.IN_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.CSUM = csum_q;
`endif

endmodule

// File: tb/tb_coef_table_loader.sv
// Directed bench for coef_table_loader: table-driven read checks plus hand-written frame sequences
// (full, back-to-back short, long/flush, read/write collision, mid-frame reset).
module tb_coef_table_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;

  always #5 clk = ~clk;

  coef_table_loader_if #(.NX(8), .ROWS(4), .COLS(4)) bus ();

  coef_table_loader #(.NX(8), .ROWS(4), .COLS(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.DONE === 1'b1) done_cnt++;
    if (bus.ERR === 1'b1) err_cnt++;
    if (bus.DONE === 1'b1 && bus.ERR === 1'b1) both_cnt++;
  end

  typedef struct {
    int          phase;
    int          row;
    int          col;
    logic [7:0]  exp;
    string       name;
  } rd_vec_t;

  rd_vec_t vecs [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int ph, input int r, input int c, input logic [7:0] e, input string n);
    rd_vec_t v;
    v.phase = ph; v.row = r; v.col = c; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic run_reads(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        bus.RD_ROW = 2'(vecs[i].row);
        bus.RD_COL = 2'(vecs[i].col);
        step();
        check(vecs[i].name, {24'd0, bus.RD_DATA}, {24'd0, vecs[i].exp});
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int gap);
    repeat (gap) begin
      bus.IN_VALID = 1'b0;
      step();
    end
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = d;
    bus.IN_LAST  = last;
    step();
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
  endtask

  task automatic start_frame();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  initial begin
    int d0, e0;
    logic busy_ok;

    add_vec(0, 1, 2, 8'd6,  "img_r1c2");
    add_vec(0, 2, 3, 8'd11, "img_r2c3");
    add_vec(0, 0, 0, 8'd0,  "img_r0c0");
    add_vec(0, 3, 3, 8'd15, "img_r3c3");
    add_vec(1, 0, 0, 8'd15, "full_r0c0");
    add_vec(1, 1, 2, 8'd9,  "full_r1c2");
    add_vec(1, 3, 3, 8'd0,  "full_r3c3");
    add_vec(1, 2, 1, 8'd6,  "full_r2c1");
    add_vec(2, 0, 0, 8'hAA, "short_r0c0");
    add_vec(2, 0, 3, 8'hAA, "short_r0c3");
    add_vec(2, 1, 0, 8'hAA, "short_r1c0");
    add_vec(2, 1, 1, 8'h0A, "short_r1c1_kept");
    add_vec(2, 1, 2, 8'h09, "short_r1c2_kept");
    add_vec(3, 0, 0, 8'h30, "long_r0c0");
    add_vec(3, 2, 1, 8'h39, "long_r2c1");
    add_vec(3, 3, 3, 8'h3F, "long_r3c3");
    add_vec(4, 0, 0, 8'd0,  "rst_img_r0c0");
    add_vec(4, 0, 1, 8'd1,  "rst_img_r0c1");
    add_vec(4, 1, 2, 8'd6,  "rst_img_r1c2");
    add_vec(4, 3, 3, 8'd15, "rst_img_r3c3");

    bus.START = 1'b0; bus.IN_DATA = '0; bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0;
    bus.RD_ROW = 2'd3; bus.RD_COL = 2'd3;

    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    check("rst_busy",     {31'd0, bus.BUSY},     32'd0);
    check("rst_done",     {31'd0, bus.DONE},     32'd0);
    check("rst_err",      {31'd0, bus.ERR},      32'd0);
    check("rst_rd_data",  {24'd0, bus.RD_DATA},  32'd0);
    rst = 1'b0;
    run_reads(0);

    // Full frame with random gaps
    d0 = done_cnt; e0 = err_cnt;
    start_frame();
    check("load_busy",     {31'd0, bus.BUSY},     32'd1);
    check("load_in_ready", {31'd0, bus.IN_READY}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      send(8'(15 - i), (i == 15), int'($urandom_range(0, 2)));
    end
    check("full_done_now", {31'd0, bus.DONE}, 32'd1);
    check("full_busy_low", {31'd0, bus.BUSY}, 32'd0);
`ifdef COEF_TABLE_LOADER_CSUM_EN
    check("full_csum", {24'd0, bus.CSUM}, 32'd120);
`endif
    // Back-to-back: START in the DONE cycle
    start_frame();
    check("b2b_busy",     {31'd0, bus.BUSY}, 32'd1);
    check("full_done_1x", done_cnt - d0, 32'd1);
    check("full_err_0",   err_cnt - e0,  32'd0);

    // Short frame of 5 words
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) send(8'hAA, (i == 4), 0);
    check("short_err_now", {31'd0, bus.ERR}, 32'd1);
    step();
    check("short_err_1x",  err_cnt - e0,  32'd1);
    check("short_done_0",  done_cnt - d0, 32'd0);
`ifdef COEF_TABLE_LOADER_CSUM_EN
    check("short_csum", {24'd0, bus.CSUM}, 32'h52);
`endif
    run_reads(1'b0 ? 1 : 2);

    // Long frame of 20 words: last 4 flushed
    d0 = done_cnt; e0 = err_cnt;
    busy_ok = 1'b1;
    start_frame();
    for (int i = 0; i < 20; i++) begin
      busy_ok &= (bus.BUSY === 1'b1) && (bus.IN_READY === 1'b1);
      send(8'(8'h30 + i), (i == 19), 0);
      if (i < 19) begin
        check($sformatf("long_no_err_w%0d", i), {31'd0, bus.ERR}, 32'd0);
        i = i;
      end
    end
    check("long_busy_thru", {31'd0, busy_ok}, 32'd1);
    check("long_err_now",   {31'd0, bus.ERR}, 32'd1);
    step();
    check("long_err_1x",  err_cnt - e0,  32'd1);
    check("long_done_0",  done_cnt - d0, 32'd0);
`ifdef COEF_TABLE_LOADER_CSUM_EN
    check("long_csum", {24'd0, bus.CSUM}, 32'h78);
`endif
    run_reads(3);

    // Read/write collision on (0,1)
    bus.RD_ROW = 2'd0; bus.RD_COL = 2'd1;
    start_frame();
    send(8'h11, 1'b0, 0);
    send(8'h5C, 1'b1, 0);
    check("coll_old", {24'd0, bus.RD_DATA}, 32'h31);
    step();
    check("coll_new", {24'd0, bus.RD_DATA}, 32'h5C);

    // Mid-frame reset; START during LOAD must not restart the counter
    d0 = done_cnt; e0 = err_cnt;
    start_frame();
    for (int i = 0; i < 3; i++) send(8'(8'hE0 + i), 1'b0, 0);
    start_frame();
    for (int i = 3; i < 7; i++) send(8'(8'hE0 + i), 1'b0, 0);
    bus.RD_ROW = 2'd1; bus.RD_COL = 2'd2;
    step();
    check("mid_r1c2_w7", {24'd0, bus.RD_DATA}, 32'hE6);
    bus.IN_VALID = 1'b1; bus.IN_DATA = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy",     {31'd0, bus.BUSY},     32'd0);
    check("mrst_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    repeat (3) step();
    bus.IN_VALID = 1'b0;
    check("mrst_idle_ready", {31'd0, bus.IN_READY}, 32'd0);
`ifdef COEF_TABLE_LOADER_CSUM_EN
    check("mrst_csum", {24'd0, bus.CSUM}, 32'd0);
`endif
    run_reads(4);
    check("mrst_no_done", done_cnt - d0, 32'd0);
    check("mrst_no_err",  err_cnt - e0,  32'd0);
    check("never_both",   both_cnt,      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
